// File: rtl/mux_ula_operand_q_pkg.sv
// Shared definitions for the ALU operand selector slice.
// WORD_W is the default datapath width.
// alu_src_e names the operand sources wired to the selector inputs, so
// decode logic can drive the selector symbolically.
package mux_ula_operand_q_pkg;

  localparam int WORD_W = 32;

  // Selector encodings for the standard four-source operand mux.
  typedef enum logic [1:0] {
    ALU_SRC_PC    = 2'd0,
    ALU_SRC_REG_A = 2'd1,
    ALU_SRC_MDR   = 2'd2,
    ALU_SRC_ZERO  = 2'd3
  } alu_src_e;

  // Occupancy width for a buffer of the given depth. The extra bit lets
  // "full" be told apart from "empty".
  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mux_ula_operand_q_if.sv
// Handshake bundle between the operand sources, the selector buffer and the ALU.
// master: the surrounding datapath (source side plus ALU consumer).
// slave : the operand selector/buffer.
//   in_valid/in_ready   source handshake
//   selector/data_in    operand index and flattened candidates
//   flush               discard everything buffered
//   out_valid/out_ready ALU handshake
//   out_data/out_sel    head operand and the selector that chose it
//   sel_err             one-cycle pulse after an out-of-range selector is accepted
//   count               current occupancy
interface mux_ula_operand_q_if
  import mux_ula_operand_q_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int N_INPUTS = 4,
  parameter int DEPTH    = 2
);
  localparam int SEL_W = $clog2(N_INPUTS);
  localparam int CNT_W = cntWidth(DEPTH);

  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          selector;
  logic [N_INPUTS*WIDTH-1:0] data_in;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      sel_err;
  logic [CNT_W-1:0]          count;

  modport master (
    output in_valid, selector, data_in, flush, out_ready,
    input  in_ready, out_valid, out_data, out_sel, sel_err, count
  );

  modport slave (
    input  in_valid, selector, data_in, flush, out_ready,
    output in_ready, out_valid, out_data, out_sel, sel_err, count
  );

endinterface

// File: rtl/mux_ula_operand_q_mux.sv
// Purely combinational N:1 word selector.
// A select value with no matching input falls back to input 0 and raises oor_o,
// so a non-power-of-two source count always yields a defined word.
//   data_i  flattened candidates, input k = data_i[k*WIDTH +: WIDTH]
//   sel_i   candidate index
//   data_o  selected word
//   oor_o   sel_i >= N_INPUTS
module mux_ula_operand_q_mux #(
  parameter int WIDTH    = 32,
  parameter int N_INPUTS = 4,
  localparam int SEL_W   = $clog2(N_INPUTS)
) (
  input  logic [N_INPUTS*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]          sel_i,
  output logic [WIDTH-1:0]          data_o,
  output logic                      oor_o
);

  // Start from the out-of-range answer and let a matching index override it.
  always_comb begin
    data_o = data_i[WIDTH-1:0];
    oor_o  = 1'b1;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (int'(sel_i) == k) begin
        data_o = data_i[k*WIDTH +: WIDTH];
        oor_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_ula_operand_q.sv
// ALU operand selector with a small registered output buffer.
// The selected operand and its raw selector are captured on a valid/ready push
// and presented to the ALU from the buffer head. This lets the ALU stall
// without losing operands.
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   bus       slave side of mux_ula_operand_q_if (handshakes, data, flush, status)
module mux_ula_operand_q
  import mux_ula_operand_q_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int N_INPUTS = 4,
  parameter int DEPTH    = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  mux_ula_operand_q_if.slave  bus
);

  localparam int SEL_W = $clog2(N_INPUTS);
  localparam int CNT_W = cntWidth(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] dataMem [DEPTH];
  logic [SEL_W-1:0] selMem  [DEPTH];

  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             selErr_q, selErr_d;

  logic [WIDTH-1:0] muxWord;
  logic             muxOor;
  logic             push, pop;

  mux_ula_operand_q_mux #(
    .WIDTH    (WIDTH),
    .N_INPUTS (N_INPUTS)
  ) u_mux (
    .data_i (bus.data_in),
    .sel_i  (bus.selector),
    .data_o (muxWord),
    .oor_o  (muxOor)
  );

  // Ready and valid come only from the registered occupancy.
  // This keeps a combinational in->out path from forming.
  // The head word reads as zero while empty, so reset shows a clean output.
  always_comb begin
    bus.in_ready  = (count_q != CNT_W'(DEPTH));
    bus.out_valid = (count_q != '0);
    bus.out_data  = bus.out_valid ? dataMem[rdPtr_q] : '0;
    bus.out_sel   = bus.out_valid ? selMem[rdPtr_q]  : '0;
    bus.sel_err   = selErr_q;
    bus.count     = count_q;
  end

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Next-state logic. Flush overrides everything, including a push offered
  // in the same cycle. Otherwise each pointer advances on its own handshake.
  // Occupancy only changes when exactly one side fires.
  always_comb begin
    rdPtr_d  = rdPtr_q;
    wrPtr_d  = wrPtr_q;
    count_d  = count_q;
    selErr_d = 1'b0;
    if (bus.flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;
      selErr_d = push && muxOor;
    end
  end

  // Control state registers. These clear immediately on reset, so any
  // buffered operands are lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr_q  <= '0;
      wrPtr_q  <= '0;
      count_q  <= '0;
      selErr_q <= 1'b0;
    end else begin
      rdPtr_q  <= rdPtr_d;
      wrPtr_q  <= wrPtr_d;
      count_q  <= count_d;
      selErr_q <= selErr_d;
    end
  end

  // Storage has no reset. Count gates what is visible, so stale contents
  // never reach the ALU. The raw selector is kept even when out of range.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      dataMem[wrPtr_q] <= muxWord;
      selMem[wrPtr_q]  <= bus.selector;
    end
  end

  // Simulation-only sanity checks on occupancy and the handshake gating.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (count_q <= CNT_W'(DEPTH));
      assert (!(push && count_q == CNT_W'(DEPTH)));
      assert (!(pop && count_q == '0));
    end
  end

endmodule

// File: tb/tb_mux_ula_operand_q.sv
// Directed and randomized bench for mux_ula_operand_q.
// A three-input DUT also covers the out-of-range selector case.
// The reference model is a pair of queues holding the operands the ALU should
// see, plus the expected error pulse.
module tb_mux_ula_operand_q;

  localparam int WIDTH    = 32;
  localparam int N_INPUTS = 3;
  localparam int DEPTH    = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  mux_ula_operand_q_if #(.WIDTH(WIDTH), .N_INPUTS(N_INPUTS), .DEPTH(DEPTH)) bus ();

  mux_ula_operand_q #(.WIDTH(WIDTH), .N_INPUTS(N_INPUTS), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] w [4];
  logic [31:0] qData [$];
  logic [1:0]  qSel  [$];
  logic        expErr = 1'b0;

  // One comparison: count it, and report tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model.
  task automatic compareModel(input string tag);
    checkOutput({tag, ":out_valid"}, 32'(bus.out_valid), 32'(qData.size() != 0));
    checkOutput({tag, ":in_ready"},  32'(bus.in_ready),  32'(qData.size() < DEPTH));
    checkOutput({tag, ":count"},     32'(bus.count),     32'(qData.size()));
    checkOutput({tag, ":sel_err"},   32'(bus.sel_err),   32'(expErr));
    if (qData.size() != 0) begin
      checkOutput({tag, ":out_data"}, bus.out_data,       qData[0]);
      checkOutput({tag, ":out_sel"},  32'(bus.out_sel),   32'(qSel[0]));
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check ready before
  // the rising edge. After that edge, update the model and compare outputs.
  task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic fl,
                               input logic ordy, input string tag);
    logic        push, pop;
    logic [31:0] word;
    @(negedge clk);
    bus.in_valid  = v;
    bus.selector  = sel;
    bus.flush     = fl;
    bus.out_ready = ordy;
    bus.data_in   = {w[2], w[1], w[0]};
    #1;
    checkOutput({tag, ":in_ready_pre"}, 32'(bus.in_ready), 32'(qData.size() < DEPTH));
    push = v && (qData.size() < DEPTH);
    pop  = ordy && (qData.size() != 0);
    word = (int'(sel) < N_INPUTS) ? w[sel] : w[0];
    @(posedge clk);
    #1;
    if (fl) begin
      qData.delete();
      qSel.delete();
      expErr = 1'b0;
    end else begin
      if (pop) begin
        void'(qData.pop_front());
        void'(qSel.pop_front());
      end
      if (push) begin
        qData.push_back(word);
        qSel.push_back(sel);
      end
      expErr = push && (int'(sel) >= N_INPUTS);
    end
    compareModel(tag);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.selector  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_in   = '0;
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;

    // Power-on reset state.
    repeat (2) @(posedge clk);
    #1;
    compareModel("reset");
    checkOutput("reset:out_data", bus.out_data, 32'h0);
    checkOutput("reset:out_sel", 32'(bus.out_sel), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic selection: input 2 appears one edge after the push.
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1, "select");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, "select_drain");

    // Backpressure: the third push is refused while full, and the head is held.
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, "bp_push0");
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, "bp_push1");
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, "bp_refused");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, "bp_hold");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, "bp_pop0");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, "bp_pop1");

    // Simultaneous push and pop at occupancy 1 over several pointer wraps.
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, "pp_fill");
    for (int i = 0; i < 8; i++) begin
      w[0] = $urandom; w[1] = $urandom; w[2] = $urandom;
      applyStimulus(1'b1, 2'(i % 4), 1'b0, 1'b1, "pushpop");
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, "pp_drain");

    // Out-of-range selector: input 0 is stored with the raw selector,
    // and the error pulses for one cycle.
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, "range");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, "range_after");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, "range_drain");

    // Flush while full with a push offered, then flush a partly full buffer
    // with both a push and a pop offered.
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, "fl_fill0");
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, "fl_fill1");
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, "flush_full");
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, "fl_fill2");
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b1, "flush_push");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 300; i++) begin
      w[0] = $urandom; w[1] = $urandom; w[2] = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), "random");
    end

    // Asynchronous reset in mid-cycle with operands buffered.
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, "prereset");
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    qData.delete();
    qSel.delete();
    expErr = 1'b0;
    compareModel("async_reset");
    checkOutput("async_reset:out_data", bus.out_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, "post_reset");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, "post_reset_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
